// File: rtl/imem_boot_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | boot_pkg                                                           |
// | Shared types and constants for the instruction-memory boot loader  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package boot_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } boot_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_boot_loader_if                                                |
// | Byte-stream input handshake plus instruction-memory write port     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Byte source / memory observer side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader_word_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | word_assembler                                                     |
// | Packs little-endian payload bytes into 32-bit words                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] lanes;

  // The top byte lane is never stored: the completed word is formed on
  // the fly from the 4th byte so the write can be registered in one step.
  assign word_done = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word      = {byte_in, lanes};

  // Lane insert and byte counter, advancing only on accepted payload bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      lanes    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_boot_loader                                                   |
// | Framed byte-stream loader for the rv32i instruction memory; holds  |
// | the core in reset until a checksum-verified image is written       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                core_reset_n,
  output logic                done,
  output logic                error
);

  boot_state_t       state, next_state;
  logic              hs;
  logic              data_hs;
  logic [7:0]        count_lo;
  logic [15:0]       count;
  logic [15:0]       len_full;
  logic              last_word;
  logic [CSUM_W-1:0] sum;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       asm_word;
  logic              asm_done;

  // Ready depends on state alone so it never loops back through rx_valid
  assign bus.rx_ready = (state != S_DONE) && (state != S_ERR);
  assign hs           = bus.rx_valid && bus.rx_ready;
  assign data_hs      = hs && (state == S_DATA);
  assign len_full     = {bus.rx_data, count_lo};
  assign last_word    = (16'(word_cnt) == (count - 16'd1));

  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign core_reset_n = (state == S_DONE);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (data_hs),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .word_done  (asm_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LEN0;
    else       state <= next_state;
  end

  // Frame parsing: length check, payload word count, checksum verdict
  always_comb begin
    next_state = state;
    case (state)
      S_LEN0: if (hs) next_state = S_LEN1;
      S_LEN1: begin
        if (hs) begin
          if (len_full > 16'(IMEM_DEPTH)) next_state = S_ERR;
          else if (len_full == 16'd0)     next_state = S_CSUM;
          else                            next_state = S_DATA;
        end
      end
      S_DATA: if (asm_done && last_word) next_state = S_CSUM;
      S_CSUM: begin
        if (hs) next_state = (bus.rx_data == sum) ? S_DONE : S_ERR;
      end
      S_DONE:  next_state = S_DONE;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_LEN0;
    endcase
  end

  // Length latch, running checksum, word counter and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_lo       <= 8'd0;
      count          <= 16'd0;
      sum            <= '0;
      word_cnt       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      if (hs && (state == S_LEN0)) count_lo <= bus.rx_data;
      if (hs && (state == S_LEN1)) count    <= len_full;
      if (data_hs)                 sum      <= sum + bus.rx_data;
      if (asm_done) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= word_cnt;
        bus.imem_wdata <= asm_word;
        word_cnt       <= word_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_boot_loader                                                |
// | Table-driven bench for the boot loader plus multi-cycle sequences  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_imem_boot_loader;
  import boot_pkg::*;

  localparam int IMEM_DEPTH = 1024;
  localparam int ADDR_W     = 10;

  logic clk = 1'b0;
  logic reset;
  logic core_reset_n, done, error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          valid;
    logic [7:0]  data;
    bit          ready;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    bit          dn;
    bit          er;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  log_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] nom [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                           8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void v(bit valid, logic [7:0] d, bit ready, bit we,
                            logic [9:0] a, logic [31:0] w, bit dn, bit er);
    vec_t r;
    r.do_rst = 1'b0; r.valid = valid; r.data = d; r.ready = ready;
    r.we = we; r.addr = a; r.wdata = w; r.dn = dn; r.er = er;
    vecs.push_back(r);
  endfunction

  function automatic void rst_row();
    vec_t r;
    r = '{do_rst: 1'b1, valid: 1'b0, data: 8'h00, ready: 1'b1, we: 1'b0,
          addr: 10'd0, wdata: 32'd0, dn: 1'b0, er: 1'b0};
    vecs.push_back(r);
  endfunction

  task automatic check_reset_state(string tag);
    chk({tag, " ready"}, 32'(bus.rx_ready), 32'd1);
    chk({tag, " we"}, 32'(bus.imem_we), 32'd0);
    chk({tag, " addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, " wdata"}, bus.imem_wdata, 32'd0);
    chk({tag, " core_reset_n"}, 32'(core_reset_n), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " error"}, 32'(error), 32'd0);
  endtask

  task automatic pulse_reset(string tag);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(bit valid, logic [7:0] d);
    wr_t w;
    @(negedge clk);
    bus.rx_valid = valid;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    if (bus.imem_we === 1'b1) begin
      w.a = bus.imem_addr;
      w.d = bus.imem_wdata;
      log_q.push_back(w);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 check_reset_state("init");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Partial frame then reset: byte lane counter must restart
    v(1, 8'h02, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'hAA, 1, 0, 0, 0, 0, 0);
    rst_row();
    // Nominal load with stalls
    v(1, 8'h02, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h13, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(0, 8'h55, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 1, 10'd0, 32'h0000_0013, 0, 0);
    v(1, 8'h93, 1, 0, 0, 0, 0, 0);
    v(0, 8'h77, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h10, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 1, 10'd1, 32'h0010_0093, 0, 0);
    v(0, 8'hB6, 1, 0, 0, 0, 0, 0);
    v(1, 8'hB6, 0, 0, 0, 0, 1, 0);
    v(1, 8'hFF, 0, 0, 0, 0, 1, 0);
    rst_row();
    // Bad checksum
    v(1, 8'h02, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h13, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 1, 10'd0, 32'h0000_0013, 0, 0);
    v(1, 8'h93, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h10, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 1, 10'd1, 32'h0010_0093, 0, 0);
    v(1, 8'hB7, 0, 0, 0, 0, 0, 1);
    v(1, 8'hB6, 0, 0, 0, 0, 0, 1);
    rst_row();
    // Oversize count 1025
    v(1, 8'h01, 1, 0, 0, 0, 0, 0);
    v(1, 8'h04, 0, 0, 0, 0, 0, 1);
    v(1, 8'h00, 0, 0, 0, 0, 0, 1);
    v(1, 8'h00, 0, 0, 0, 0, 0, 1);
    v(1, 8'h00, 0, 0, 0, 0, 0, 1);
    rst_row();
    // Empty image, good and bad checksum
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 0, 0, 0, 0, 1, 0);
    rst_row();
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h00, 1, 0, 0, 0, 0, 0);
    v(1, 8'h05, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        pulse_reset($sformatf("row%0d rst", i));
      end else begin
        step(vecs[i].valid, vecs[i].data);
        chk($sformatf("row%0d ready", i), 32'(bus.rx_ready), 32'(vecs[i].ready));
        chk($sformatf("row%0d we", i), 32'(bus.imem_we), 32'(vecs[i].we));
        chk($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].dn));
        chk($sformatf("row%0d error", i), 32'(error), 32'(vecs[i].er));
        chk($sformatf("row%0d core_reset_n", i), 32'(core_reset_n), 32'(vecs[i].dn));
        if (vecs[i].we) begin
          chk($sformatf("row%0d addr", i), 32'(bus.imem_addr), 32'(vecs[i].addr));
          chk($sformatf("row%0d wdata", i), bus.imem_wdata, vecs[i].wdata);
        end
      end
    end

    // Backpressure: random idle gaps between bytes
    pulse_reset("bp rst");
    log_q.delete();
    for (int i = 0; i < 11; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom));
      step(1'b1, nom[i]);
    end
    step(1'b0, 8'h00);
    chk("bp writes", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("bp addr0", 32'(log_q[0].a), 32'd0);
      chk("bp data0", log_q[0].d, 32'h0000_0013);
      chk("bp addr1", 32'(log_q[1].a), 32'd1);
      chk("bp data1", log_q[1].d, 32'h0010_0093);
    end
    chk("bp done", 32'(done), 32'd1);
    chk("bp core_reset_n", 32'(core_reset_n), 32'd1);

    // Reset mid-load right as the first strobe is high
    pulse_reset("mid rst0");
    for (int i = 0; i < 6; i++) step(1'b1, nom[i]);
    chk("mid strobe before reset", 32'(bus.imem_we), 32'd1);
    bus.rx_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_state("mid during reset");
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    for (int i = 0; i < 11; i++) step(1'b1, nom[i]);
    chk("mid writes", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("mid addr0", 32'(log_q[0].a), 32'd0);
      chk("mid data0", log_q[0].d, 32'h0000_0013);
      chk("mid addr1", 32'(log_q[1].a), 32'd1);
    end
    chk("mid done", 32'(done), 32'd1);

    // Maximal image: N == IMEM_DEPTH is accepted and fills every address
    pulse_reset("max rst");
    log_q.delete();
    begin
      logic [7:0] csum;
      csum = 8'h00;
      step(1'b1, 8'h00);
      step(1'b1, 8'h04);
      chk("max len ready", 32'(bus.rx_ready), 32'd1);
      chk("max len error", 32'(error), 32'd0);
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        step(1'b1, 8'(i));
        step(1'b1, 8'(i >> 8));
        step(1'b1, 8'h00);
        step(1'b1, 8'h5A);
        csum = csum + 8'(i) + 8'(i >> 8) + 8'h5A;
      end
      chk("max done before csum", 32'(done), 32'd0);
      step(1'b1, csum);
    end
    chk("max writes", 32'(log_q.size()), 32'(IMEM_DEPTH));
    for (int i = 0; i < log_q.size(); i++) begin
      chk($sformatf("max addr%0d", i), 32'(log_q[i].a), 32'(i));
      chk($sformatf("max data%0d", i), log_q[i].d, {8'h5A, 8'h00, 8'(i >> 8), 8'(i)});
    end
    chk("max done", 32'(done), 32'd1);
    chk("max error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream boot loader that sits directly upstream of the rv32i core's instruction memory. It accepts a framed program image on a valid/ready byte interface and assembles little-endian 32-bit words. It writes those words sequentially into the instruction memory from word address 0. The core is held in reset until a complete image with a matching checksum has been written.

## Interface
- `IMEM_DEPTH`, 1024: instruction memory depth in 32-bit words.
- `ADDR_W`, $clog2(IMEM_DEPTH): word-address width.
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte; the transfer occurs when `rx_valid && rx_ready` at posedge.
- `imem_we` out 1: one-cycle write strobe to instruction memory.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: word to write.
- `core_reset_n` out 1: active-low reset to the rv32i core; 0 until load succeeds.
- `done` out 1: image loaded and verified; sticky until `reset`.
- `error` out 1: length or checksum failure; sticky until `reset`.

## Operation
- Frame format:
  - 2-byte word count N, little-endian.
  - N×4 payload bytes, each word little-endian.
  - 1 checksum byte, equal to the sum of all payload bytes mod 256.
  - The count bytes are excluded from the checksum.
- FSM states: `S_LEN0`, `S_LEN1`, `S_DATA`, `S_CSUM`, `S_DONE`, `S_ERR`. Reset state is `S_LEN0`.
- `S_LEN0`: on handshake, latch the count low byte and go to `S_LEN1`.
- `S_LEN1`: on handshake, latch the count high byte, then:
  - N > `IMEM_DEPTH` → `S_ERR`.
  - N == 0 → `S_CSUM`, expected checksum 0x00.
  - Otherwise → `S_DATA`.
- `S_DATA`:
  - A 2-bit byte counter selects the lane: byte k goes to bits [8k+7:8k].
  - Each payload byte is added to an 8-bit running sum, wrapping mod 256.
  - On the 4th byte, issue one write and increment the word counter.
  - After word N-1 is written, go to `S_CSUM`.
- `S_CSUM`: on handshake, a match with the running sum → `S_DONE`; a mismatch → `S_ERR`.
- `S_DONE`: `rx_ready`=0, `done`=1, `core_reset_n`=1. Terminal.
- `S_ERR`: `rx_ready`=0, `error`=1, `core_reset_n`=0. Terminal. Words already written stay in memory, but the core never starts.
- `rx_ready` is 1 in `S_LEN0`, `S_LEN1`, `S_DATA` and `S_CSUM`; it is combinational from state only, never from `rx_valid`.
- Bytes presented while `rx_ready`=0 are ignored.

## Timing
- Reset values:
  - `rx_ready`=1 (state `S_LEN0`)
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `core_reset_n`=0, `done`=0, `error`=0
  - running sum 0, byte counter 0, word counter 0.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is high for exactly the one cycle after the handshake of a word's 4th byte. `imem_addr` equals that word's index during the strobe.
- `done`/`core_reset_n` rise, or `error` rises, in the cycle after the deciding handshake.
- The final data write and `done` are never in the same cycle, because at least one cycle separates them for the checksum byte.
- Stalls with `rx_valid`=0 of any length do not change state or counters.
- Back-to-back bytes are accepted at one per cycle; a maximal image takes 4·N+3 accepted bytes.
- Asserting `reset` mid-load immediately returns all state and outputs to their reset values, with no write strobe in flight. Reloading then restarts at word address 0.
- Word-counter wrap: unreachable, because N ≤ `IMEM_DEPTH` is enforced before `S_DATA`.

## Structure
- Package `boot_pkg` holds:
  - the `boot_state_t` enum;
  - `LEN_BYTES`=2 and `BYTES_PER_WORD`=4;
  - `CSUM_W`=8.
- One natural sub-module, `word_assembler`: byte lane shift/insert, the 2-bit byte counter and the word-complete pulse. The FSM, counters, checksum and memory port stay in `imem_boot_loader`.
- Instruction memory gets a write port (`imem_we`/`imem_addr`/`imem_wdata`). The core's `reset_n` is driven by `core_reset_n`.

## Test plan
- Nominal load: stream 02 00 13 00 00 00 93 00 10 00 B6 → writes (0, 0x00000013) then (1, 0x00100093), each one cycle; next cycle after B6 `done`=1, `core_reset_n`=1, `rx_ready`=0.
- Bad checksum: same stream ending B7 → both words written; `error`=1, `core_reset_n` stays 0, `done`=0.
- Oversize: count 01 04 (1025) with `IMEM_DEPTH`=1024 → `error`=1 after the 2nd byte; no `imem_we` ever; subsequent bytes ignored.
- Empty image: 00 00 00 → `done`=1, no writes; 00 00 05 → `error`=1.
- Backpressure gaps: nominal stream with `rx_valid` randomly low 0-5 cycles between bytes → identical writes and `done`, with no duplicate strobes.
- Reset mid-load: assert `reset` after 6 bytes of the nominal stream, then resend the full stream → all outputs at reset values during reset; writes restart at address 0; `done`=1.
